lfsr_crypt_seq: RTL and testbench
=================================

// Module: lfsr_crypt_seq
// PURPOSE
//  Control FSM for the LFSR packet-encryption datapath.
//  - On start, reads three config words from the read-only config memory: preamble length, tap pattern, seed.
//  - Initialises the LFSR, emits the preamble bytes, then pops plaintext bytes from the input FIFO.
//  - Advances the LFSR once per byte emitted, until PKT_LEN bytes have left the block; then pulses done.
//  - Sits beside the datapath and drives all of its enables; holds no data bytes itself.
// PARAMETERS
//  AW       4   config-memory address width
//  PKT_LEN  32  total bytes per packet, preamble included
//  CW       6   byte-counter width; must hold PKT_LEN
// PORTS
//  clk         in   1    clock
//  rst         in   1    synchronous, active-high reset
//  start       in   1    begin one packet; sampled only in IDLE
//  pre_len     in   4    preamble length register value from the datapath
//  fifo_valid  in   1    input FIFO has a byte at its head
//  out_ready   in   1    downstream accepts a byte this cycle
//  raddr       out  AW   config-memory read address (async-read memory)
//  prelen_en   out  1    capture memory data into the preamble-length register
//  taps_en     out  1    capture memory data into the taps register
//  seed_en     out  1    capture memory data into the seed register
//  lfsr_init   out  1    load the seed into the LFSR
//  lfsr_en     out  1    advance the LFSR one step
//  fifo_pop    out  1    pop the FIFO head
//  sel_pre     out  1    1 = output mux selects preamble byte, 0 = FIFO byte
//  valid_out   out  1    encrypted byte on datapath output is valid
//  byte_cnt    out  CW   bytes emitted so far in this packet
//  busy        out  1    FSM not in IDLE
//  done        out  1    one-cycle pulse at packet end
// BEHAVIOUR
//  Reset (and any cycle with rst=1, including mid-packet)
//  - FSM goes to IDLE, byte_cnt=0, every output 0, raddr=0.
//  - FIFO contents are not touched by this block.
//  States: IDLE, RD_LEN, RD_TAPS, RD_SEED, INIT, PRE, PAY, FIN.
//  IDLE
//  - start=1 -> RD_LEN next cycle; byte_cnt cleared to 0.
//  - start in any other state is ignored.
//  Config reads, one cycle each, unconditional (data captured at the clock edge ending the state):
//  - RD_LEN:  raddr=0, prelen_en=1 -> RD_TAPS
//  - RD_TAPS: raddr=1, taps_en=1   -> RD_SEED
//  - RD_SEED: raddr=2, seed_en=1   -> INIT
//  INIT
//  - lfsr_init=1.
//  - Goes to PRE if pre_len!=0, else PAY; pre_len is already registered here.
//  - Preamble length used is min(pre_len, PKT_LEN).
//  PRE
//  - sel_pre=1, valid_out=1.
//  - On out_ready: lfsr_en=1, byte_cnt+=1.
//  - After the accepted byte that makes byte_cnt==pre_len: -> PAY, or -> FIN if that byte_cnt==PKT_LEN.
//  PAY
//  - sel_pre=0, valid_out=fifo_valid.
//  - Handshake = fifo_valid & out_ready; on handshake: fifo_pop=1, lfsr_en=1, byte_cnt+=1 (all in the same cycle).
//  - No pop and no LFSR step without a handshake; FIFO empty stalls with valid_out=0.
//  - After the handshake that makes byte_cnt==PKT_LEN: -> FIN.
//  FIN
//  - done=1 for exactly one cycle -> IDLE.
//  - byte_cnt holds PKT_LEN until the next start.
//  busy=1 in every state except IDLE.
//  Latency: start to first valid_out = 5 cycles (IDLE->RD_LEN->RD_TAPS->RD_SEED->INIT->PRE/PAY).
//  Guarantees
//  - lfsr_en and lfsr_init are never both 1.
//  - fifo_pop never asserts while fifo_valid=0.
//  - byte_cnt never exceeds PKT_LEN.
//  Outputs are Moore-decoded from state, except handshake-qualified ones (lfsr_en, fifo_pop, valid_out in PAY).
// TESTING
//  1. pre_len=5, FIFO preloaded with 27 bytes, out_ready=1
//     -> 5 preamble bytes then 27 pops; done at cycle 5+32 after start; byte_cnt=32.
//  2. FIFO empty for 3 cycles mid-payload
//     -> valid_out=0, fifo_pop=0, lfsr_en=0 while empty; byte_cnt frozen; resumes without loss.
//  3. out_ready toggled 1,0,1,0 during PRE
//     -> lfsr_en and byte_cnt advance only on out_ready=1 cycles.
//  4. pre_len=0 -> INIT goes straight to PAY; 32 pops; no sel_pre=1 cycle.
//  5. rst asserted at byte_cnt=10
//     -> next cycle IDLE, all outputs 0; a fresh start re-reads raddr 0,1,2 in order.
//  6. start pulsed during PAY
//     -> ignored; exactly one done per packet; second start after done begins a new packet.

Source files
------------

// File: rtl/lfsr_crypt_seq.sv
// lfsr_crypt_seq
// Control sequencer for the LFSR packet-encryption datapath. It fetches the
// three config words, seeds the LFSR, steers the preamble bytes and then the
// FIFO payload bytes to the output, and pulses done after PKT_LEN bytes.
// It only drives enables and selects; every data byte lives in the datapath.

module lfsr_crypt_seq #(
  parameter int AW      = 4,
  parameter int PKT_LEN = 32,
  parameter int CW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    pre_len,
  input  logic          fifo_valid,
  input  logic          out_ready,
  output logic [AW-1:0] raddr,
  output logic          prelen_en,
  output logic          taps_en,
  output logic          seed_en,
  output logic          lfsr_init,
  output logic          lfsr_en,
  output logic          fifo_pop,
  output logic          sel_pre,
  output logic          valid_out,
  output logic [CW-1:0] byte_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LEN,
    RD_TAPS,
    RD_SEED,
    INIT,
    PRE,
    PAY,
    FIN
  } state_t;

  localparam logic [CW-1:0] PktLenC  = CW'(PKT_LEN);
  localparam logic [CW-1:0] OneC     = CW'(1);
  localparam logic [AW-1:0] AddrLen  = AW'(0);
  localparam logic [AW-1:0] AddrTaps = AW'(1);
  localparam logic [AW-1:0] AddrSeed = AW'(2);

  state_t        state_q, state_d;
  logic [CW-1:0] byteCnt_q, byteCnt_d;
  logic [AW-1:0] raddr_q;
  logic          prelenEn_q;
  logic          tapsEn_q;
  logic          seedEn_q;
  logic          lfsrInit_q;
  logic          selPre_q;
  logic          busy_q;
  logic          done_q;

  logic          inPre;
  logic          inPay;
  logic          payHandshake;
  logic          byteAccepted;
  logic [CW-1:0] cntInc;
  logic [CW-1:0] preLimit;
  logic          preTooLong;

  // The preamble can never be longer than the packet itself, so the
  // register value is clamped to PKT_LEN before it is used as a limit.
  assign preTooLong = ({28'd0, pre_len} > 32'(PKT_LEN));
  assign preLimit   = preTooLong ? PktLenC : CW'(pre_len);

  // Handshake qualification: a preamble byte needs only downstream ready,
  // a payload byte also needs a byte at the FIFO head.
  assign inPre        = (state_q == PRE);
  assign inPay        = (state_q == PAY);
  assign payHandshake = inPay & fifo_valid & out_ready;
  assign byteAccepted = (inPre & out_ready) | payHandshake;
  assign cntInc       = byteCnt_q + OneC;

  // These outputs must react in the same cycle as the handshake inputs,
  // so they are decoded combinationally from the registered state.
  assign valid_out = inPre | (inPay & fifo_valid);
  assign lfsr_en   = byteAccepted;
  assign fifo_pop  = payHandshake;

  // Next-state and byte-counter logic for the packet sequence.
  always_comb begin
    state_d   = state_q;
    byteCnt_d = byteCnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RD_LEN;
          byteCnt_d = '0;
        end
      end
      RD_LEN:  state_d = RD_TAPS;
      RD_TAPS: state_d = RD_SEED;
      RD_SEED: state_d = INIT;
      INIT: begin
        if (preLimit != '0) begin
          state_d = PRE;
        end else begin
          state_d = PAY;
        end
      end
      PRE: begin
        if (out_ready) begin
          byteCnt_d = cntInc;
          if (cntInc >= preLimit) begin
            if (cntInc >= PktLenC) begin
              state_d = FIN;
            end else begin
              state_d = PAY;
            end
          end
        end
      end
      PAY: begin
        if (payHandshake) begin
          byteCnt_d = cntInc;
          if (cntInc >= PktLenC) begin
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and the Moore outputs, the latter registered from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byteCnt_q  <= '0;
      raddr_q    <= '0;
      prelenEn_q <= 1'b0;
      tapsEn_q   <= 1'b0;
      seedEn_q   <= 1'b0;
      lfsrInit_q <= 1'b0;
      selPre_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byteCnt_q  <= byteCnt_d;
      case (state_d)
        RD_TAPS: raddr_q <= AddrTaps;
        RD_SEED: raddr_q <= AddrSeed;
        default: raddr_q <= AddrLen;
      endcase
      prelenEn_q <= (state_d == RD_LEN);
      tapsEn_q   <= (state_d == RD_TAPS);
      seedEn_q   <= (state_d == RD_SEED);
      lfsrInit_q <= (state_d == INIT);
      selPre_q   <= (state_d == PRE);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == FIN);
    end
  end

  assign raddr     = raddr_q;
  assign prelen_en = prelenEn_q;
  assign taps_en   = tapsEn_q;
  assign seed_en   = seedEn_q;
  assign lfsr_init = lfsrInit_q;
  assign sel_pre   = selPre_q;
  assign byte_cnt  = byteCnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lfsr_crypt_seq.sv
// tb_lfsr_crypt_seq
// Scoreboard bench for the encryption sequencer: stimulus pushes the expected
// config reads, per-byte records and done events; a negedge monitor pops and
// compares whenever the sequencer presents the matching output.

module tb_lfsr_crypt_seq;

  localparam int PKT = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pre_len;
  logic       fifo_valid;
  logic       out_ready;
  logic [3:0] raddr;
  logic       prelen_en;
  logic       taps_en;
  logic       seed_en;
  logic       lfsr_init;
  logic       lfsr_en;
  logic       fifo_pop;
  logic       sel_pre;
  logic       valid_out;
  logic [5:0] byte_cnt;
  logic       busy;
  logic       done;

  typedef struct {
    logic       selPre;
    logic [5:0] cnt;
  } byte_exp_t;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] ens;
  } cfg_exp_t;

  byte_exp_t byteQ[$];
  cfg_exp_t  cfgQ[$];
  int        doneQ[$];

  int   vectors     = 0;
  int   miscompares = 0;
  int   cycleNo     = 0;
  int   startCyc    = 0;
  int   doneSeen    = 0;
  int   fifoLoaded  = 0;
  int   fifoPopped  = 0;
  logic stall       = 1'b0;

  logic      hs;
  byte_exp_t be;
  cfg_exp_t  ce;
  int        dexp;

  lfsr_crypt_seq #(.AW(4), .PKT_LEN(PKT), .CW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pre_len    (pre_len),
    .fifo_valid (fifo_valid),
    .out_ready  (out_ready),
    .raddr      (raddr),
    .prelen_en  (prelen_en),
    .taps_en    (taps_en),
    .seed_en    (seed_en),
    .lfsr_init  (lfsr_init),
    .lfsr_en    (lfsr_en),
    .fifo_pop   (fifo_pop),
    .sel_pre    (sel_pre),
    .valid_out  (valid_out),
    .byte_cnt   (byte_cnt),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time start-to-done latency.
  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Input FIFO model: a byte count that the sequencer drains via fifo_pop.
  always @(posedge clk) if (fifo_pop && (fifoLoaded - fifoPopped) > 0) fifoPopped <= fifoPopped + 1;

  assign fifo_valid = ((fifoLoaded - fifoPopped) > 0) && !stall;

  // One comparison; prints a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Queue the expected config reads, bytes and done event for one packet.
  task automatic expectPacket(input int pre);
    int lim;
    lim = (pre > PKT) ? PKT : pre;
    cfgQ.push_back('{addr: 4'd0, ens: 4'b1000});
    cfgQ.push_back('{addr: 4'd1, ens: 4'b0100});
    cfgQ.push_back('{addr: 4'd2, ens: 4'b0010});
    cfgQ.push_back('{addr: 4'd0, ens: 4'b0001});
    for (int i = 0; i < PKT; i++) byteQ.push_back('{selPre: (i < lim), cnt: 6'(i)});
    doneQ.push_back(PKT);
  endtask

  // Start one packet with the given preamble length and FIFO fill.
  task automatic applyStimulus(input int pre, input int fifoBytes);
    pre_len    = 4'(pre);
    fifoLoaded = fifoPopped + fifoBytes;
    expectPacket(pre);
    startCyc = cycleNo;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Bounded wait for done, then check latency and the return to IDLE.
  task automatic waitDone(input string name, input int expLat);
    int guard;
    guard = 0;
    while (!done && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!done) begin
      checkOutput({name, "_done_timeout"}, 0, 1);
    end else begin
      if (expLat >= 0) checkOutput({name, "_latency"}, cycleNo - startCyc, expLat);
      @(posedge clk);
      #1;
      checkOutput({name, "_busy_after"}, busy, 0);
      checkOutput({name, "_cnt_hold"}, byte_cnt, PKT);
      checkOutput({name, "_bytes_left"}, byteQ.size(), 0);
    end
  endtask

  // Bounded wait until byte_cnt reaches a value (sampled after the edge).
  task automatic waitCount(input string name, input int target);
    int guard;
    guard = 0;
    while (int'(byte_cnt) != target && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (int'(byte_cnt) != target) checkOutput({name, "_cnt_timeout"}, byte_cnt, target);
  endtask

  // Monitor: compares every presented byte, config read and done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      hs = valid_out && out_ready;
      checkOutput("lfsr_en_vs_handshake", lfsr_en, hs);
      checkOutput("fifo_pop_vs_handshake", fifo_pop, hs && !sel_pre);
      checkOutput("init_and_step", lfsr_en && lfsr_init, 0);
      if (valid_out && !sel_pre) checkOutput("valid_without_fifo", fifo_valid, 1);
      if (hs) begin
        if (byteQ.size() == 0) begin
          checkOutput("unexpected_byte", 1, 0);
        end else begin
          be = byteQ.pop_front();
          checkOutput("byte_sel_pre", sel_pre, be.selPre);
          checkOutput("byte_cnt", byte_cnt, be.cnt);
        end
      end
      if (prelen_en || taps_en || seed_en || lfsr_init) begin
        if (cfgQ.size() == 0) begin
          checkOutput("unexpected_cfg", 1, 0);
        end else begin
          ce = cfgQ.pop_front();
          checkOutput("cfg_raddr", raddr, ce.addr);
          checkOutput("cfg_enables", {prelen_en, taps_en, seed_en, lfsr_init}, ce.ens);
        end
      end
      if (done) begin
        doneSeen++;
        checkOutput("done_busy", busy, 1);
        if (doneQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          dexp = doneQ.pop_front();
          checkOutput("done_cnt", byte_cnt, dexp);
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    int frozen;
    int doneBefore;
    rst       = 1'b1;
    start     = 1'b0;
    pre_len   = 4'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_raddr", raddr, 0);
    checkOutput("rst_cnt", byte_cnt, 0);

    // Test 1: 5 preamble bytes, 27 payload bytes, ready throughout.
    out_ready = 1'b1;
    applyStimulus(5, 27);
    waitDone("t1", 37);
    checkOutput("t1_fifo_empty", fifoLoaded - fifoPopped, 0);

    // Test 2: FIFO empty for 3 cycles mid-payload.
    applyStimulus(3, 29);
    waitCount("t2", 12);
    frozen = int'(byte_cnt);
    stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t2_stall_valid", valid_out, 0);
      checkOutput("t2_stall_pop", fifo_pop, 0);
      checkOutput("t2_stall_step", lfsr_en, 0);
      @(posedge clk);
      #1;
      checkOutput("t2_stall_cnt", byte_cnt, frozen);
    end
    stall = 1'b0;
    waitDone("t2", 40);

    // Test 3: out_ready toggled 1,0,1,0 at the start of the preamble.
    applyStimulus(6, 26);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t3_in_pre", sel_pre, 1);
    checkOutput("t3_cnt_start", byte_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      out_ready = ((i % 2) == 0);
      @(posedge clk);
      #1;
    end
    checkOutput("t3_cnt_after_toggle", byte_cnt, 2);
    out_ready = 1'b1;
    waitDone("t3", 39);

    // Test 4: no preamble, straight to payload.
    applyStimulus(0, 32);
    waitDone("t4", 37);

    // Test 5: reset mid-packet, then a fresh packet.
    applyStimulus(4, 28);
    waitCount("t5", 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_valid", valid_out, 0);
    checkOutput("t5_sel_pre", sel_pre, 0);
    checkOutput("t5_step", lfsr_en, 0);
    checkOutput("t5_pop", fifo_pop, 0);
    checkOutput("t5_done", done, 0);
    checkOutput("t5_raddr", raddr, 0);
    checkOutput("t5_cnt", byte_cnt, 0);
    rst = 1'b0;
    byteQ.delete();
    cfgQ.delete();
    doneQ.delete();
    applyStimulus(2, 30);
    waitDone("t5b", 37);

    // Test 6: start pulsed mid-payload is ignored; second start works.
    doneBefore = doneSeen;
    applyStimulus(1, 31);
    waitCount("t6", 20);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("t6", 37);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t6_one_done", doneSeen - doneBefore, 1);
    checkOutput("t6_idle", busy, 0);
    applyStimulus(0, 32);
    waitDone("t6b", 37);
    checkOutput("t6_two_done", doneSeen - doneBefore, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
